// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter
//   Round-robin arbiter that shares the async FIFO write port among NUM_REQ
//   producers in the wclk domain. A grant lasts for up to BURST_MAX words.
//   The grant ends early if the holder drops req_valid. While wfull is high,
//   the current grant is held.
//
// Optional build macro: WR_ARB_STATS_EN
//   When defined, stall_cnt counts the cycles in which the grant holder has
//   a word ready but wfull blocks it. The counter saturates at 16'hFFFF and
//   is cleared only by reset. When undefined, stall_cnt is tied to zero.
//
// Ports
//   wclk, wrst_n : write-domain clock; asynchronous active-low reset
//   req_valid    : per-requester "word available"
//   req_data     : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : per-requester "word accepted this cycle" (one-hot or 0)
//   wfull        : FIFO full flag
//   winc, wdata  : FIFO write enable / data
//   gnt_id       : index of the current grant holder
//   gnt_busy     : high while a grant is active
//   stall_cnt    : wfull stall counter (see macro above)
//
// state | meaning
// IDLE  | no grant; pick the next valid requester starting at rr_ptr
// GRANT | gnt_id owns the write port until its burst ends or it drops valid
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          gnt_busy,
  output logic [15:0]                   stall_cnt
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   gnt_id_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic               xfer;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   gnt_inc;

  assign gnt_busy = (state == GRANT);
  assign xfer     = gnt_busy & req_valid[gnt_id] & ~wfull;
  assign winc     = xfer;
  assign wdata    = req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_inc  = IDX_W'((int'(gnt_id) + 1) % NUM_REQ);

  always_comb begin
    req_ready         = '0;
    req_ready[gnt_id] = xfer;
  end

  // The search starts at rr_ptr and wraps, so the requester just after the
  // previous holder gets first chance at the port.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    gnt_id_nxt    = gnt_id;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = GRANT;
          gnt_id_nxt = pick;
        end
      end
      GRANT: begin
        if (xfer && burst_cnt == BURST_W'(BURST_MAX - 1)) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
          rr_ptr_nxt    = gnt_inc;
        end else if (!req_valid[gnt_id]) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
          rr_ptr_nxt    = gnt_inc;
        end else if (xfer) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        // Otherwise wfull is blocking the holder: keep the grant and the count.
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      gnt_id    <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt_id    <= gnt_id_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

`ifdef WR_ARB_STATS_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if (gnt_busy && req_valid[gnt_id] && wfull && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb_async_fifo_wr_arbiter
//   Directed bench for async_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
//   BURST_MAX=4). Each test pushes the words it expects to be written into a
//   scoreboard queue. A negedge monitor pops one entry per winc and compares
//   it with wdata, gnt_id and req_ready. Requester data is {id, word count},
//   and the count advances only after an accepted word.
//   The stall_cnt expectations follow WR_ARB_STATS_EN.
module tb_async_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int BM      = 4;

  logic                  wclk;
  logic                  wrst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DW-1:0]         wdata;
  logic [1:0]            gnt_id;
  logic                  gnt_busy;
  logic [15:0]           stall_cnt;

  async_fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
    .gnt_id(gnt_id), .gnt_busy(gnt_busy), .stall_cnt(stall_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [3:0]   word_n [NUM_REQ];
  logic [3:0]   exp_n  [NUM_REQ];
  logic [NUM_REQ-1:0] acc;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      word_n[i] = '0;
      exp_n[i]  = '0;
    end
    acc = '0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      req_data[i*DW +: DW] = {4'(i), word_n[i]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(id);
      e.data = {4'(id), exp_n[id]};
      exp_q.push_back(e);
      exp_n[id] = exp_n[id] + 4'd1;
    end
  endtask

  // Monitor: one scoreboard entry per FIFO write.
  always @(negedge wclk) begin
    exp_t e;
    acc = req_ready;
    if (wrst_n === 1'b1) begin
      if (winc === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got id %0d data %0h expected no write", gnt_id, wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(wdata), 32'(e.data));
          check("wr_gnt_id", 32'(gnt_id), 32'(e.id));
          check("wr_ready_onehot", 32'(req_ready), 32'(4'b0001 << e.id));
        end
      end else begin
        check("ready_without_winc", 32'(req_ready), 32'h0);
      end
    end
  end

  // A requester presents its next word only after the current word is accepted.
  always @(posedge wclk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) word_n[i] = word_n[i] + 4'd1;
  end

  task automatic reset_dut();
    @(posedge wclk); #1;
    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  logic [9:0]  pat10;
  logic [24:0] pat_w, pat_b;
  logic [15:0] exp_stall;

  initial begin
    req_valid = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b1;
    #2 wrst_n = 1'b0;
    #1;
    check("rst_winc", 32'(winc), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(gnt_busy), 32'h0);
    check("rst_gnt_id", 32'(gnt_id), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    @(posedge wclk); #1 wrst_n = 1'b1;

    // Single requester: 0,1,1,1,1,0,1,1,1,1
    reset_dut();
    push(0, 8);
    req_valid = 4'b0001;
    pat10 = '0;
    repeat (10) begin
      @(negedge wclk);
      pat10 = {pat10[8:0], winc};
    end
    check("t1_winc_pattern", 32'(pat10), 32'(10'b0111101111));
    check("t1_gnt_id", 32'(gnt_id), 32'h0);
    @(posedge wclk); #1 req_valid = '0;
    repeat (2) @(negedge wclk);

    // All requesters: grants 0,1,2,3,0 with one bubble between them
    reset_dut();
    push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
    req_valid = 4'b1111;
    pat_w = '0;
    pat_b = '0;
    repeat (25) begin
      @(negedge wclk);
      pat_w = {pat_w[23:0], winc};
      pat_b = {pat_b[23:0], gnt_busy};
    end
    check("t2_winc_pattern", 32'(pat_w), 32'({5{5'b01111}}));
    check("t2_busy_pattern", 32'(pat_b), 32'({5{5'b01111}}));
    @(posedge wclk); #1 req_valid = '0;
    repeat (2) @(negedge wclk);

    // wfull stall for 3 cycles after the 2nd word
    reset_dut();
    push(0, 4);
    req_valid = 4'b0001;
    repeat (3) @(negedge wclk);
    @(posedge wclk); #1 wfull = 1'b1;
    repeat (3) begin
      @(negedge wclk);
      check("t3_stall_winc", 32'(winc), 32'h0);
      check("t3_stall_busy", 32'(gnt_busy), 32'h1);
    end
    @(posedge wclk); #1 wfull = 1'b0;
    repeat (2) begin
      @(negedge wclk);
      check("t3_resume_winc", 32'(winc), 32'h1);
    end
    @(posedge wclk); #1 req_valid = '0;
    @(negedge wclk);
    check("t3_release_busy", 32'(gnt_busy), 32'h0);
`ifdef WR_ARB_STATS_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    check("t3_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    // Early release: requester 2 drops after one word, requester 3 waiting
    reset_dut();
    push(2, 1); push(3, 4);
    req_valid = 4'b1100;
    @(negedge wclk);
    @(negedge wclk);
    check("t4_first_gnt", 32'(gnt_id), 32'h2);
    @(posedge wclk); #1 req_valid = 4'b1000;
    @(negedge wclk);
    check("t4_drop_winc", 32'(winc), 32'h0);
    @(negedge wclk);
    check("t4_idle_busy", 32'(gnt_busy), 32'h0);
    @(negedge wclk);
    check("t4_next_gnt", 32'(gnt_id), 32'h3);
    check("t4_next_busy", 32'(gnt_busy), 32'h1);
    repeat (3) @(negedge wclk);
    @(posedge wclk); #1 req_valid = '0;
    repeat (2) @(negedge wclk);

    // Reset mid-burst, then 4'b1010 grants requester 1 first
    reset_dut();
    push(0, 2);
    req_valid = 4'b0001;
    repeat (3) @(negedge wclk);
    @(posedge wclk); #1 wrst_n = 1'b0;
    #1;
    check("t5_rst_winc", 32'(winc), 32'h0);
    check("t5_rst_busy", 32'(gnt_busy), 32'h0);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    push(1, 4); push(3, 4);
    req_valid = 4'b1010;
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
    @(negedge wclk);
    check("t5_arb_busy", 32'(gnt_busy), 32'h0);
    @(negedge wclk);
    check("t5_first_gnt", 32'(gnt_id), 32'h1);
    repeat (8) @(negedge wclk);
    @(posedge wclk); #1 req_valid = '0;
    repeat (2) @(negedge wclk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
